dma_unpack: RTL and testbench
=============================

# dma_unpack

Downstream neighbour of the DDR DMA stage. It accepts 128-bit beats from the DMA over a valid/ready handshake and buffers them in a small beat FIFO. It serializes each beat into eight 16-bit half-precision words for the convolution engine, and it bounds consumption to a programmed transfer length. It also marks the final word of each transfer.

## Interface
Parameters:
- IN_W, 128, input beat width (bits)
- OUT_W, 16, output word width; IN_W/OUT_W = LANES = 8
- FIFO_DEPTH, 4, beat FIFO entries (power of two)
- LEN_W, 16, width of transfer length in words

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- len  in  LEN_W  words to emit; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at transfer end
- in_valid  in  1  DMA beat valid
- in_ready  out  1  unpacker accepts beat
- in_data  in  IN_W  DMA beat; lane 0 = bits [15:0]
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_data  out  OUT_W  output word
- out_last  out  1  qualifies final word of transfer

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE → RUN on start with len≠0. Latch len. beats_needed = ceil(len/8), computed in LEN_W bits without overflow: (len>>3) + |len[2:0].
- IDLE → FLUSH on start with len=0. No beat is ever accepted.
- RUN → FLUSH when the last word handshakes (out_valid & out_ready & out_last).
- FLUSH → IDLE after one cycle. done=1 for that cycle; busy drops in the same cycle.
- start while busy is ignored.
- in_ready = (state==RUN) & !fifo_full & (beats_accepted < beats_needed). The unpacker never over-consumes past the transfer.
- Lane order: lane 0 first, lane 7 last. Lanes beyond len in the final beat are discarded. The FIFO entry is popped after the last valid lane of the beat is emitted.
- Word counter counts emitted words. out_last = out_valid & (words_emitted == len-1).
- out_valid and out_data hold stable while out_ready is low.
- Reset at any time returns to IDLE and empties the FIFO. A partially delivered transfer is abandoned with no done pulse.
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_last=0. Counters and FIFO pointers reset to 0.

## Timing
- FIFO write is registered. First out_valid occurs 2 cycles after the first in_valid & in_ready handshake.
- Sustained throughput: 1 word/cycle with out_ready held high. One beat is consumed every 8 cycles, and the FIFO never starves when the DMA keeps in_valid high.
- A simultaneous push and pop with the FIFO full is legal. in_ready is computed from the registered full flag, so no push occurs that cycle; the pop frees the entry for the next cycle.
- Pop from an empty FIFO never occurs. The lane selector only advances when the head is valid.
- done pulses exactly 1 cycle after the last-word handshake. For len=0, done pulses 1 cycle after start.

## Configuration
- Macro DMA_UNPACK_BYTESWAP_EN.
- Defined: each output word is byte-swapped ({out[7:0], out[15:8]}) before the output register, for big-endian host images.
- Undefined: words pass through unchanged.
- Latency is identical in both builds.

## Structure
- Shared package dma_pkg holds:
  - IN_W, OUT_W, LANES, LEN_W constants
  - state enum {IDLE, RUN, FLUSH}
  - beats_needed rounding helper function
- Sub-module dma_beat_fifo: synchronous FIFO, FIFO_DEPTH × IN_W, with full/empty flags and registered write. Async active-low reset on pointers only.
- Top holds the FSM, lane selector, counters, output register and byte-swap.

## Test plan
- len=16, two beats with lane k = 0x0000+k and 0x0008+k → outputs 0x0000..0x000F in order; out_last only on 0x000F; done 1 cycle after; exactly 2 beats accepted.
- len=5, DMA offers 3 beats → 1 beat accepted, in_ready low afterwards; words 0..4 emitted; lanes 5–7 never appear; out_last on word 4.
- len=0 → in_ready never asserts; done pulses at start+1; busy stays 0 after it.
- len=64, out_ready low for 20 cycles mid-stream → FIFO fills to 4, in_ready low, out_data stable; all 64 words delivered in order on release.
- rst_n asserted after 10 words of a len=32 transfer → all outputs 0 immediately; no done; new start with len=8 completes normally.
- With DMA_UNPACK_BYTESWAP_EN defined, lane value 0x1234 → out_data 0x3412; without the macro, 0x1234.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared widths, FSM state type and beat-count rounding for the DMA unpacker
package dma_pkg;
  localparam int IN_W = 128;
  localparam int OUT_W = 16;
  localparam int LANES = IN_W / OUT_W;
  localparam int LEN_W = 16;
  localparam int LANE_BITS = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  function automatic logic [LEN_W-1:0] beats_needed(input logic [LEN_W-1:0] n);
    return (n >> LANE_BITS) + LEN_W'(|n[LANE_BITS-1:0]);
  endfunction
endpackage

// File: rtl/dma_beat_fifo.sv
// dma_beat_fifo: synchronous beat FIFO with registered write and full/empty flags
module dma_beat_fifo
  import dma_pkg::*;
#(
  parameter int W = IN_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  // pointers carry a wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end
  // storage is not reset; only entries between the pointers are meaningful
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) & (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/dma_unpack.sv
// dma_unpack: buffers 128-bit DMA beats and serializes them into 16-bit words bounded by a transfer length (DMA_UNPACK_BYTESWAP_EN byte-swaps each word)
module dma_unpack #(
  parameter int IN_W = dma_pkg::IN_W,
  parameter int OUT_W = dma_pkg::OUT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W = dma_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);
  localparam int LANES = IN_W / OUT_W;
  localparam int LW = $clog2(LANES);
  dma_pkg::state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, need_q, need_d, beats_q, beats_d, words_q, words_d;
  logic [LW-1:0] lane_q, lane_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OUT_W-1:0] out_data_q, out_data_d, word, word_x;
  logic [IN_W-1:0] head;
  logic full, empty, push, pop, load, last_word, beat_end, fin;
  dma_beat_fifo #(.W(IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );
  assign in_ready = (state_q == dma_pkg::RUN) & ~full & (beats_q < need_q);
  assign push = in_valid & in_ready;
  assign load = (state_q == dma_pkg::RUN) & ~empty & (~out_valid_q | out_ready);
  assign word = head[lane_q*OUT_W +: OUT_W];
  assign last_word = words_q == len_q - 1'b1;
  assign beat_end = (lane_q == LW'(LANES - 1)) | last_word;
  assign pop = load & beat_end;
  assign fin = out_valid_q & out_ready & out_last_q;
`ifdef DMA_UNPACK_BYTESWAP_EN
  assign word_x = {word[OUT_W/2-1:0], word[OUT_W-1:OUT_W/2]};
`else
  assign word_x = word;
`endif
  assign busy = state_q == dma_pkg::RUN;
  assign done = state_q == dma_pkg::FLUSH;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  // next-state: transfer FSM, counters, lane selector and output register
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    need_d = need_q;
    beats_d = beats_q;
    words_d = words_q;
    lane_d = lane_q;
    out_valid_d = load ? 1'b1 : out_valid_q & ~out_ready;
    out_data_d = load ? word_x : out_data_q;
    out_last_d = load ? last_word : out_last_q;
    if (state_q == dma_pkg::IDLE) begin
      if (start) begin
        state_d = (len == '0) ? dma_pkg::FLUSH : dma_pkg::RUN;
        len_d = len;
        need_d = dma_pkg::beats_needed(len);
        beats_d = '0;
        words_d = '0;
        lane_d = '0;
      end
    end else if (state_q == dma_pkg::RUN) begin
      beats_d = beats_q + LEN_W'(push);
      words_d = words_q + LEN_W'(load);
      lane_d = load ? (beat_end ? '0 : lane_q + 1'b1) : lane_q;
      state_d = fin ? dma_pkg::FLUSH : dma_pkg::RUN;
    end else begin
      state_d = dma_pkg::IDLE;
    end
  end
  // state and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= dma_pkg::IDLE;
      len_q <= '0;
      need_q <= '0;
      beats_q <= '0;
      words_q <= '0;
      lane_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      need_q <= need_d;
      beats_q <= beats_d;
      words_q <= words_d;
      lane_q <= lane_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_dma_unpack.sv
// tb_dma_unpack: directed self-checking bench for the DMA beat unpacker
module tb_dma_unpack;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] len;
  logic [127:0] in_data;
  logic [15:0] out_data;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  dma_unpack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  function automatic logic [15:0] ew(input logic [15:0] v);
`ifdef DMA_UNPACK_BYTESWAP_EN
    return {v[7:0], v[15:8]};
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // lane k of beat b carries off + 8*b + k; the consumer stalls stall_n cycles once wi==stall_at
  task automatic run(input int n, input int nb, input logic [15:0] off,
                     input int stall_at, input int stall_n, input int abort_at);
    logic [127:0] bt [8];
    int bi, wi, cyc, st, first_hs, first_ov, fin_cyc;
    bit fin;
    bi = 0; wi = 0; cyc = 0; st = 0; first_hs = -1; first_ov = -1; fin_cyc = 0; fin = 0;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 8; k++) bt[b][k*16 +: 16] = off + 16'(8 * b + k);
    start = 1'b1;
    len = 16'(n);
    tick();
    start = 1'b0;
    #1 chk("busy_start", {31'b0, busy}, 1);
    while (!fin && cyc < 1000 && !(abort_at >= 0 && wi == abort_at)) begin
      in_valid = bi < nb;
      in_data = (bi < nb) ? bt[bi & 7] : '0;
      start = (cyc == 3);
      len = 16'd3;
      out_ready = !(wi == stall_at && st < stall_n);
      #1;
      if (!out_ready) begin
        st++;
        if (st == stall_n) begin
          chk("stall_valid", {31'b0, out_valid}, 1);
          chk("stall_data", {16'b0, out_data}, {16'b0, ew(off + 16'(wi))});
          chk("stall_in_ready", {31'b0, in_ready}, 0);
          chk("stall_beats", bi, 5);
        end
      end
      if (out_valid && first_ov < 0) begin
        first_ov = cyc;
        chk("latency", first_ov - first_hs, 2);
      end
      if (out_valid && out_ready) begin
        chk("word", {16'b0, out_data}, {16'b0, ew(off + 16'(wi))});
        chk("last", {31'b0, out_last}, {31'b0, wi == n - 1});
        if (out_last) begin
          fin = 1;
          fin_cyc = cyc;
        end
        wi++;
      end
      if (in_valid && in_ready) begin
        if (first_hs < 0) first_hs = cyc;
        bi++;
      end
      cyc++;
      tick();
    end
    start = 1'b0;
    if (abort_at < 0) begin
      chk("finished", {31'b0, fin}, 1);
      chk("beats", bi, (n + 7) / 8);
      chk("words", wi, n);
      if (stall_n == 0) chk("throughput", fin_cyc - first_ov, n - 1);
      #1;
      chk("done", {31'b0, done}, 1);
      chk("busy_end", {31'b0, busy}, 0);
      chk("in_ready_end", {31'b0, in_ready}, 0);
      tick();
      #1 chk("done_pulse", {31'b0, done}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_out_data"}, {16'b0, out_data}, 0);
    chk({tag, "_out_last"}, {31'b0, out_last}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(16, 2, 16'h0000, -1, 0, -1);
    run(5, 3, 16'h0000, -1, 0, -1);
    start = 1'b1;
    len = '0;
    in_valid = 1'b1;
    in_data = '1;
    #1 chk("zero_in_ready", {31'b0, in_ready}, 0);
    tick();
    start = 1'b0;
    #1;
    chk("zero_done", {31'b0, done}, 1);
    chk("zero_busy", {31'b0, busy}, 0);
    chk("zero_in_ready2", {31'b0, in_ready}, 0);
    tick();
    #1;
    chk("zero_done_off", {31'b0, done}, 0);
    chk("zero_busy_after", {31'b0, busy}, 0);
    chk("zero_in_ready3", {31'b0, in_ready}, 0);
    in_valid = 1'b0;
    tick();
    run(64, 8, 16'h0000, 10, 20, -1);
    run(32, 4, 16'h0000, -1, 0, 10);
    rst_n = 1'b0;
    #1 chk_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("abort_no_done", {31'b0, done}, 0);
    end
    run(8, 1, 16'h0100, -1, 0, -1);
    run(1, 1, 16'h1234, -1, 0, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
